// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, FSM state encoding and PSLVERR response constants.
package apb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;
endpackage

// File: rtl/apb_reg_completer_if.sv
// apb_reg_completer_if: APB bus bundle between the bridge (master) and the register completer (slave).
interface apb_reg_completer_if;
    import apb_pkg::*;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: RW register array with byte-strobe writes, a sampled read-only status
// register at the top index, and the read mux.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] strb,
    input  logic [DATA_W-1:0] status_in,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ctrl_out
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++)
                for (int n = 0; n < STRB_W; n++)
                    if (we && idx == IW'(i) && strb[n]) regs[i][8*n +: 8] <= wdata[8*n +: 8];
            regs[NUM_REGS-1] <= status_in;
        end
    end

    assign rdata    = regs[idx];
    assign ctrl_out = regs[0];
endmodule

// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB completer with a small register bank, fixed wait states and PSLVERR decode.
// Wait-state counter is compiled in only when APB_COMPLETER_WAIT_EN is defined.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int              NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              WAIT_CYCLES = 2
) (
    input  logic               s_apb_pclk,
    input  logic               s_apb_presetn,
    apb_reg_completer_if.slave s_apb,
    output logic [DATA_W-1:0]  ctrl_out,
    input  logic [DATA_W-1:0]  status_in
);
    localparam int IW = $clog2(NUM_REGS);

    if (NUM_REGS < 2 || NUM_REGS > 256 || BASE_ADDR[1:0] != 2'b00 ||
        WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
        $error("apb_reg_completer: illegal parameter set");
    end

    state_t            state;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-3:0] idx;
    logic              err;
    logic              done;
    logic              commit;
    logic [DATA_W-1:0] rdata;

    assign off = s_apb.paddr - BASE_ADDR;
    assign idx = off[ADDR_W-1:2];
    assign err = (off[1:0] != 2'b00) || (idx >= (ADDR_W-2)'(NUM_REGS)) ||
                 (s_apb.pwrite && idx == (ADDR_W-2)'(NUM_REGS - 1));

    assign s_apb.pready  = state == ACCESS && s_apb.psel && s_apb.penable && done;
    assign s_apb.pslverr = (s_apb.pready && err) ? RESP_ERR : RESP_OKAY;
    assign s_apb.prdata  = (s_apb.pready && !s_apb.pwrite && !err) ? rdata : '0;
    assign commit        = s_apb.pready && s_apb.pwrite && !err;

`ifdef APB_COMPLETER_WAIT_EN
    logic [3:0] cnt;
    assign done = cnt == 4'd0;

    always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
        if (!s_apb_presetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (s_apb.psel && !s_apb.penable) begin
                state <= ACCESS;
                cnt   <= 4'(WAIT_CYCLES);
            end
        end else if (!s_apb.psel || s_apb.pready) begin
            state <= IDLE;
        end else if (s_apb.penable) begin
            cnt <= cnt - 4'd1;
        end
    end
`else
    assign done = 1'b1;

    always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
        if (!s_apb_presetn) state <= IDLE;
        else if (state == IDLE) state <= (s_apb.psel && !s_apb.penable) ? ACCESS : IDLE;
        else if (!s_apb.psel || s_apb.pready) state <= IDLE;
    end
`endif

    // Out-of-range indices never commit or reach prdata, so truncation is safe.
    apb_reg_bank #(.NUM_REGS(NUM_REGS), .IW(IW)) u_bank (
        .clk       (s_apb_pclk),
        .rst_n     (s_apb_presetn),
        .we        (commit),
        .idx       (idx[IW-1:0]),
        .wdata     (s_apb.pwdata),
        .strb      (s_apb.pstrb),
        .status_in (status_in),
        .rdata     (rdata),
        .ctrl_out  (ctrl_out)
    );
endmodule
